// File: rtl/sprite_line_scheduler_pkg.sv
// sprite_line_scheduler_pkg
//   Shared types and helpers for the per-scanline sprite scheduler.
//   - sprite_attr_t : layout of one 32-bit attribute RAM word
//   - SPRITE_H      : sprite height in rows (matches the 4-bit row offset)
//   - sched_state_t : scheduler state encoding
//   - sprite_row / sprite_visible : vertical overlap test for one entry
package sprite_line_scheduler_pkg;

  localparam int SPRITE_H = 16;
  localparam int ROW_W    = 4;

  // Attribute word: [31] enable, [30] flip, [29:22] frame_id,
  // [21:12] y, [11:10] reserved, [9:0] x.
  typedef struct packed {
    logic       enable;
    logic       flip;
    logic [7:0] frame_id;
    logic [9:0] y;
    logic [1:0] rsvd;
    logic [9:0] x;
  } sprite_attr_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_EVAL      = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5,
    ST_FINISH    = 3'd6
  } sched_state_t;

  // Row of the sprite that lands on line_y. The 10-bit wrap makes a sprite
  // hanging over the top of the frame (y near 1023) land on small rows.
  function automatic logic [9:0] sprite_row(input logic [9:0] line_y,
                                            input logic [9:0] y);
    return line_y - y;
  endfunction

  // An entry is drawn on this line when enabled and the row is inside it.
  function automatic logic sprite_visible(input logic       enable,
                                          input logic [9:0] row);
    return enable && (row < 10'(SPRITE_H));
  endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// sprite_line_scheduler_if
//   Command/handshake bundle between the line scheduler and sprite_drawer.
//   master (scheduler): drives drv_start, drv_col_base, drv_flip,
//                       drv_frame_id, drv_row_off; samples drv_done.
//   slave  (drawer)   : the reverse.
//   drv_start is a one-cycle pulse; drv_done is a level that is high while
//   the drawer is idle and falls on the edge that samples drv_start.
interface sprite_line_scheduler_if;

  logic       drv_start;
  logic [9:0] drv_col_base;
  logic       drv_flip;
  logic [7:0] drv_frame_id;
  logic [3:0] drv_row_off;
  logic       drv_done;

  modport master (
    output drv_start,
    output drv_col_base,
    output drv_flip,
    output drv_frame_id,
    output drv_row_off,
    input  drv_done
  );

  modport slave (
    input  drv_start,
    input  drv_col_base,
    input  drv_flip,
    input  drv_frame_id,
    input  drv_row_off,
    output drv_done
  );

endinterface

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
//   Per-scanline sequencer for the single sprite_drawer. On line_start it
//   walks the attribute table, tests each entry for vertical overlap with
//   the requested line and, for every hit, programs the drawer and waits for
//   it to finish. Lower-index sprites are drawn first.
// Ports:
//   clk, reset    : clock; synchronous active-high reset
//   line_start    : one-cycle request to schedule line_y
//   line_y        : target scanline, sampled on line_start
//   attr_addr     : attribute RAM address (straight from the index register)
//   attr_q        : attribute word, valid the cycle after attr_addr
//   drv           : drawer command/handshake bundle (master side)
//   busy          : high whenever the walk is in progress
//   line_done     : one-cycle pulse when the walk completes
//   drawn_count   : sprites drawn on the last completed line
//   overflow      : sticky per line; a hit beyond MAX_PER_LINE was dropped
//   overrun       : one-cycle pulse (the cycle after) a line_start that
//                   arrived while busy; such a request is ignored
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter  int NUM_SPRITES  = 64,
  parameter  int MAX_PER_LINE = 16,
  localparam int IW           = $clog2(NUM_SPRITES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          line_start,
  input  logic [9:0]                    line_y,
  output logic [IW-1:0]                 attr_addr,
  input  logic [31:0]                   attr_q,
  sprite_line_scheduler_if.master       drv,
  output logic                          busy,
  output logic                          line_done,
  output logic [4:0]                    drawn_count,
  output logic                          overflow,
  output logic                          overrun
);

  sched_state_t state_r;
  sched_state_t state_next_s;

  logic [IW-1:0] index_r;
  logic [9:0]    line_y_r;
  logic [4:0]    count_r;
  logic [4:0]    drawn_count_r;
  logic          overflow_r;
  logic          overrun_r;
  logic          busy_r;
  logic          line_done_r;
  logic          drv_start_r;
  logic [9:0]    drv_col_base_r;
  logic          drv_flip_r;
  logic [7:0]    drv_frame_id_r;
  logic [3:0]    drv_row_off_r;

  sprite_attr_t  attr_s;
  logic [9:0]    row_s;
  logic          hit_s;
  logic          full_s;
  logic          last_s;
  logic          attr_rsvd_unused_s;

  assign attr_s             = sprite_attr_t'(attr_q);
  assign attr_rsvd_unused_s = ^attr_s.rsvd;
  assign row_s              = sprite_row(line_y_r, attr_s.y);
  assign hit_s              = sprite_visible(attr_s.enable, row_s);
  assign full_s             = (count_r == 5'(MAX_PER_LINE));
  assign last_s             = (index_r == IW'(NUM_SPRITES - 1));

  assign attr_addr          = index_r;
  assign busy               = busy_r;
  assign line_done          = line_done_r;
  assign drawn_count        = drawn_count_r;
  assign overflow           = overflow_r;
  assign overrun            = overrun_r;
  assign drv.drv_start      = drv_start_r;
  assign drv.drv_col_base   = drv_col_base_r;
  assign drv.drv_flip       = drv_flip_r;
  assign drv.drv_frame_id   = drv_frame_id_r;
  assign drv.drv_row_off    = drv_row_off_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode for the table walk.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (line_start) begin
          state_next_s = ST_ADDR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        state_next_s = ST_EVAL;
      end
      ST_EVAL: begin
        // A hit on a full line is dropped and walks on like a miss.
        if (hit_s && !full_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_NEXT;
        end
      end
      ST_START: begin
        state_next_s = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (drv.drv_done) begin
          state_next_s = ST_NEXT;
        end else begin
          state_next_s = ST_WAIT_DONE;
        end
      end
      ST_NEXT: begin
        if (last_s) begin
          state_next_s = ST_FINISH;
        end else begin
          state_next_s = ST_ADDR;
        end
      end
      ST_FINISH: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Status outputs, registered from the next state so they line up with
  // the state they describe (drv_start high exactly during START, etc.).
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r      <= 1'b0;
      line_done_r <= 1'b0;
      drv_start_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      busy_r      <= (state_next_s != ST_IDLE);
      line_done_r <= (state_next_s == ST_FINISH);
      drv_start_r <= (state_next_s == ST_START);
      // FINISH counts as busy, so a request landing there is also dropped.
      overrun_r   <= line_start && (state_r != ST_IDLE);
    end
  end

  // Walk datapath: line latch, index, per-line counters, drawer command.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_r        <= '0;
      line_y_r       <= 10'd0;
      count_r        <= 5'd0;
      drawn_count_r  <= 5'd0;
      overflow_r     <= 1'b0;
      drv_col_base_r <= 10'd0;
      drv_flip_r     <= 1'b0;
      drv_frame_id_r <= 8'd0;
      drv_row_off_r  <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (line_start) begin
            line_y_r   <= line_y;
            index_r    <= '0;
            count_r    <= 5'd0;
            overflow_r <= 1'b0;
          end
        end
        ST_EVAL: begin
          if (hit_s) begin
            if (!full_s) begin
              // Command stays stable until the next accepted hit.
              drv_col_base_r <= attr_s.x;
              drv_flip_r     <= attr_s.flip;
              drv_frame_id_r <= attr_s.frame_id;
              drv_row_off_r  <= row_s[ROW_W-1:0];
            end else begin
              overflow_r <= 1'b1;
            end
          end
        end
        ST_START: begin
          count_r <= count_r + 5'd1;
        end
        ST_NEXT: begin
          // Publish a cycle early so drawn_count is valid with line_done.
          if (last_s) begin
            drawn_count_r <= count_r;
          end else begin
            index_r <= index_r + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
Per-scanline sequencer for the single sprite_drawer instance. On each line_start it walks the sprite attribute table and tests each entry for vertical overlap with the requested line. For each hit it programs the drawer (col_base, flip, frame_id, row_off), pulses start, and waits for done. It sits between the video timing and attribute RAM on one side and sprite_drawer on the other, and fills the line buffer during the preceding line.

Parameters:
NUM_SPRITES, 64, attribute table entries; power of 2; index width IW = $clog2(NUM_SPRITES)
SPRITE_H, 16, sprite height in rows; must be 16 to match the 4-bit row_off
MAX_PER_LINE, 16, maximum sprites drawn per line; further hits are dropped

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
line_start  in  1  one-cycle pulse; begin scheduling for line_y
line_y  in  10  target scanline; sampled on line_start
attr_addr  out  IW  attribute RAM address; combinational from the index register
attr_q  in  32  attribute word; valid the cycle after attr_addr
drv_start  out  1  one-cycle start pulse to the drawer
drv_col_base  out  10  sprite x
drv_flip  out  1  horizontal flip
drv_frame_id  out  8  frame index
drv_row_off  out  4  row within sprite
drv_done  in  1  drawer done, level signal
busy  out  1  high whenever state != IDLE
line_done  out  1  one-cycle pulse when the table walk completes
drawn_count  out  5  sprites drawn on the last line; held until the next line_start
overflow  out  1  sticky per line; set when a hit beyond MAX_PER_LINE is dropped
overrun  out  1  one-cycle pulse when line_start arrives while busy

Behaviour:
- Attribute word layout: [31] enable, [30] flip, [29:22] frame_id, [21:12] y, [11:10] reserved, [9:0] x.
- Reset values: state IDLE; every output 0; index 0; drawn_count 0; overflow 0.
- States:
  - IDLE: on line_start, latch line_y, set index 0, clear count and overflow, go to ADDR.
  - ADDR: attr_addr = index; go to EVAL.
  - EVAL: attr_q is valid here. Compute row = (line_y_lat - y) mod 1024, a 10-bit wrap subtraction. A hit is enable=1 and row < SPRITE_H.
    - Hit with count < MAX_PER_LINE: register drv_col_base=x, drv_flip, drv_frame_id, drv_row_off=row[3:0]; go to START.
    - Hit with count = MAX_PER_LINE: set overflow; go to NEXT.
    - No hit: go to NEXT.
  - START: drv_start=1 for exactly one cycle; count++; go to WAIT_DONE.
  - WAIT_DONE: remain until drv_done=1, then go to NEXT. The drawer's done falls on the edge that samples start, so done is never observed stale.
  - NEXT: if index = NUM_SPRITES-1 go to FINISH, else index++ and go to ADDR.
  - FINISH: line_done=1 for one cycle; publish drawn_count; go to IDLE.
- drv_col_base, drv_flip, drv_frame_id and drv_row_off are stable from START until the next EVAL hit.
- Cycle cost: 3 cycles per non-hit entry (ADDR, EVAL, NEXT). A hit adds START plus the drawer duration.
- Wrap-around: a sprite with y > line_y (partially above the top, e.g. y=1020, line_y=3) yields row 7 and is drawn.
- Lower-index sprites are drawn first; later draws overwrite earlier ones in the line buffer.
- line_start while busy: pulse overrun; the request is ignored and the current walk continues.
- line_start and FINISH in the same cycle: treated as busy, so overrun pulses.
- Reset mid-operation (including WAIT_DONE): return to IDLE immediately with drv_start=0. The drawer is reset by the same reset.

Decomposition:
- sprite_pkg holds: an attribute packed-struct typedef (field positions above), the SPRITE_H constant, and the scheduler state enum.
- No sub-module. The visibility test is a small combinational function in sprite_pkg.

Test Plan:
- All entries disabled, line_start with line_y=50 -> no drv_start; line_done exactly 3*64=192 cycles after the first ADDR; drawn_count=0.
- Entry 5 = {en, flip=1, frame=0x2A, y=100, x=300}, line_y=105 -> one drv_start with col_base=300, flip=1, frame_id=0x2A, row_off=5; drawn_count=1.
- Same entry, line_y=116 -> no start. line_y=115 -> start with row_off=15.
- Entry with y=1020, line_y=3 -> start with row_off=7.
- 17 enabled entries all at y=0, line_y=0 -> exactly 16 starts (entries 0..15); overflow=1; drawn_count=16. With a behavioural drawer model, no start is issued while done=0.
- line_start during WAIT_DONE -> overrun pulse and the walk completes normally. Reset asserted during WAIT_DONE -> busy=0 the next cycle and no further drv_start.
